// File: rtl/ahblite_bram_if.sv
// AHB-Lite slave front end for a single-port-read / single-port-write BRAM with
// 1-cycle registered read data. Writes commit one cycle after acceptance
// (during the AHB write data phase). A read that hits the word being written in
// that same cycle would see stale BRAM data, so it is resolved either with one
// wait state (default) or, when BRAM_IF_RAW_BYPASS_EN is defined, by merging
// the in-flight write data into HRDATA with no wait state.
module ahblite_bram_if #(
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  HSEL,
  input  logic [31:0]           HADDR,
  input  logic [1:0]            HTRANS,
  input  logic [2:0]            HSIZE,
  input  logic                  HWRITE,
  input  logic [31:0]           HWDATA,
  input  logic                  HREADY,
  output logic                  HREADYOUT,
  output logic [31:0]           HRDATA,
  output logic                  HRESP,
  output logic [ADDR_WIDTH-1:0] BRAM_RDADDR,
  output logic [ADDR_WIDTH-1:0] BRAM_WRADDR,
  output logic [31:0]           BRAM_WDATA,
  output logic [3:0]            BRAM_WRITE,
  input  logic [31:0]           BRAM_RDATA
);

  // Byte-lane write enables for an AHB transfer of the given size and offset.
  function automatic logic [3:0] byte_mask(input logic [2:0] size, input logic [1:0] lane);
    logic [3:0] m;
    if (size == 3'd0)      m = 4'b0001 << lane;
    else if (size == 3'd1) m = lane[1] ? 4'b1100 : 4'b0011;
    else                   m = 4'b1111;
    return m;
  endfunction

  // Address phase (p0): decode of the transfer currently on the bus.
  logic                  accept_p0;
  logic [ADDR_WIDTH-1:0] addr_p0;
  logic                  hazard_p0;

  // Data phase (p1): registered write request.
  logic                  wr_vld_p1;
  logic [ADDR_WIDTH-1:0] wr_addr_p1;
  logic [3:0]            wr_mask_p1;

  // Upper address bits and HTRANS[0] carry no information for this slave.
  logic unused_bits;
  assign unused_bits = ^{HADDR[31:ADDR_WIDTH+2], HTRANS[0]};

  assign accept_p0 = HSEL & HTRANS[1] & HREADY;
  assign addr_p0   = HADDR[ADDR_WIDTH+1:2];
  assign hazard_p0 = accept_p0 & ~HWRITE & wr_vld_p1 & (addr_p0 == wr_addr_p1);

  assign HRESP       = 1'b0;
  assign BRAM_WDATA  = HWDATA;
  assign BRAM_WRADDR = wr_addr_p1;
  assign BRAM_WRITE  = wr_vld_p1 ? wr_mask_p1 : 4'b0000;

  // ---- p0 -> p1: capture accepted writes for the following data phase.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      wr_vld_p1  <= 1'b0;
      wr_addr_p1 <= '0;
      wr_mask_p1 <= 4'b0000;
    end else begin
      wr_vld_p1 <= accept_p0 & HWRITE;
      if (accept_p0 & HWRITE) begin
        wr_addr_p1 <= addr_p0;
        wr_mask_p1 <= byte_mask(HSIZE, HADDR[1:0]);
      end
    end
  end

`ifdef BRAM_IF_RAW_BYPASS_EN

  // Overlay the in-flight write lanes onto the stale BRAM word.
  function automatic logic [31:0] bypass_merge(input logic [31:0] wdata, input logic [3:0] mask,
                                               input logic [31:0] rdata);
    logic [31:0] r;
    for (int b = 0; b < 4; b++)
      r[8*b +: 8] = mask[b] ? wdata[8*b +: 8] : rdata[8*b +: 8];
    return r;
  endfunction

  logic        byp_vld_p1;
  logic [31:0] byp_data_p1;
  logic [3:0]  byp_mask_p1;

  // ---- p0 -> p1: on a hazard, hold the colliding write so the read data phase can merge it.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      byp_vld_p1  <= 1'b0;
      byp_data_p1 <= '0;
      byp_mask_p1 <= 4'b0000;
    end else begin
      byp_vld_p1 <= hazard_p0;
      if (hazard_p0) begin
        byp_data_p1 <= HWDATA;
        byp_mask_p1 <= wr_mask_p1;
      end
    end
  end

  assign HREADYOUT   = 1'b1;
  assign BRAM_RDADDR = addr_p0;
  assign HRDATA      = byp_vld_p1 ? bypass_merge(byp_data_p1, byp_mask_p1, BRAM_RDATA) : BRAM_RDATA;

`else

  typedef enum logic {IDLE, STALL} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] rd_addr_p1;

  // ---- p0 -> p1: hazard FSM state and the read address needed to re-issue a stalled read.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q    <= IDLE;
      rd_addr_p1 <= '0;
    end else begin
      state_q <= state_d;
      if (accept_p0 & ~HWRITE)
        rd_addr_p1 <= addr_p0;
    end
  end

  // Next state and outputs: a hazard costs exactly one wait cycle that re-reads the word.
  always_comb begin
    state_d     = IDLE;
    HREADYOUT   = 1'b1;
    BRAM_RDADDR = addr_p0;
    case (state_q)
      IDLE: begin
        if (hazard_p0) state_d = STALL;
      end
      STALL: begin
        HREADYOUT   = 1'b0;
        BRAM_RDADDR = rd_addr_p1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign HRDATA = BRAM_RDATA;

`endif

endmodule

// File: tb/tb_ahblite_bram_if.sv
// Directed testbench for ahblite_bram_if with a behavioural BRAM model
// (registered read, old data on same-cycle same-address write, byte enables).
module tb_ahblite_bram_if;
  localparam int AW = 12;

  logic          HCLK = 1'b0;
  logic          HRESETn;
  logic          HSEL;
  logic [31:0]   HADDR;
  logic [1:0]    HTRANS;
  logic [2:0]    HSIZE;
  logic          HWRITE;
  logic [31:0]   HWDATA;
  logic          HREADY;
  logic          HREADYOUT;
  logic [31:0]   HRDATA;
  logic          HRESP;
  logic [AW-1:0] BRAM_RDADDR;
  logic [AW-1:0] BRAM_WRADDR;
  logic [31:0]   BRAM_WDATA;
  logic [3:0]    BRAM_WRITE;
  logic [31:0]   BRAM_RDATA;

  int nerr = 0;
  int nchk = 0;
  int waits;

  always #5 HCLK = ~HCLK;

  assign HREADY = HREADYOUT;

  ahblite_bram_if #(.ADDR_WIDTH(AW)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HSIZE(HSIZE), .HWRITE(HWRITE), .HWDATA(HWDATA), .HREADY(HREADY),
    .HREADYOUT(HREADYOUT), .HRDATA(HRDATA), .HRESP(HRESP),
    .BRAM_RDADDR(BRAM_RDADDR), .BRAM_WRADDR(BRAM_WRADDR), .BRAM_WDATA(BRAM_WDATA),
    .BRAM_WRITE(BRAM_WRITE), .BRAM_RDATA(BRAM_RDATA)
  );

  // BRAM model; preloaded on its first clock edge.
  logic [31:0] mem [0:(1<<AW)-1];
  logic        mem_init_done = 1'b0;
  always @(posedge HCLK) begin
    if (!mem_init_done) begin
      for (int i = 0; i < (1 << AW); i++) mem[i] <= 32'h0;
      mem[13] <= 32'hC0DE0034;
      mem[16] <= 32'h40404040;
      mem_init_done <= 1'b1;
    end else begin
      BRAM_RDATA <= mem[BRAM_RDADDR];
      for (int b = 0; b < 4; b++)
        if (BRAM_WRITE[b]) mem[BRAM_WRADDR][8*b +: 8] <= BRAM_WDATA[8*b +: 8];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic sel, input logic [1:0] trans, input logic wr,
                       input logic [31:0] addr, input logic [2:0] size);
    HSEL = sel; HTRANS = trans; HWRITE = wr; HADDR = addr; HSIZE = size;
  endtask

  task automatic idle();
    drive(1'b0, 2'b00, 1'b0, 32'h0, 3'd0);
  endtask

  task automatic settle();
    @(negedge HCLK);
  endtask

  task automatic next();
    @(posedge HCLK);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    HRESETn = 1'b0;
    HWDATA  = 32'h0;
    idle();
    repeat (2) @(posedge HCLK);
    settle();
    chk("rst_hreadyout", 32'(HREADYOUT), 32'h1);
    chk("rst_bram_write", 32'(BRAM_WRITE), 32'h0);
    chk("rst_hresp", 32'(HRESP), 32'h0);
    next();
    HRESETn = 1'b1;
    settle();
    chk("idle_hreadyout", 32'(HREADYOUT), 32'h1);
    chk("idle_bram_write", 32'(BRAM_WRITE), 32'h0);
    chk("idle_hresp", 32'(HRESP), 32'h0);
    next();

    // Word write 0xDEADBEEF to 0x10, then read back.
    drive(1'b1, 2'b10, 1'b1, 32'h10, 3'd2); settle(); next();
    idle(); HWDATA = 32'hDEADBEEF; settle();
    chk("w10_mask", 32'(BRAM_WRITE), 32'hF);
    chk("w10_addr", 32'(BRAM_WRADDR), 32'h4);
    chk("w10_wdata", BRAM_WDATA, 32'hDEADBEEF);
    next();
    drive(1'b1, 2'b10, 1'b0, 32'h10, 3'd2); settle();
    chk("r10_rdaddr", 32'(BRAM_RDADDR), 32'h4);
    chk("r10_nowrite", 32'(BRAM_WRITE), 32'h0);
    next();
    idle(); settle();
    chk("r10_ready", 32'(HREADYOUT), 32'h1);
    chk("r10_data", HRDATA, 32'hDEADBEEF);
    next();

    // Word 0x11223344 then back-to-back byte write 0xAA to 0x13.
    drive(1'b1, 2'b10, 1'b1, 32'h10, 3'd2); settle(); next();
    HWDATA = 32'h11223344; drive(1'b1, 2'b10, 1'b1, 32'h13, 3'd0); settle();
    chk("w10b_mask", 32'(BRAM_WRITE), 32'hF);
    next();
    HWDATA = 32'hAA555555; idle(); settle();
    chk("w13_mask", 32'(BRAM_WRITE), 32'h8);
    chk("w13_addr", 32'(BRAM_WRADDR), 32'h4);
    next();
    drive(1'b1, 2'b10, 1'b0, 32'h10, 3'd2); settle(); next();
    idle(); settle();
    chk("r10b_data", HRDATA, 32'hAA223344);
    next();

    // Halfword 0x5566 to 0x22, read 0x20 immediately (same word hazard).
    drive(1'b1, 2'b10, 1'b1, 32'h22, 3'd1); settle(); next();
    HWDATA = 32'h55661234; drive(1'b1, 2'b10, 1'b0, 32'h20, 3'd2); settle();
    chk("w22_mask", 32'(BRAM_WRITE), 32'hC);
    chk("w22_ready", 32'(HREADYOUT), 32'h1);
    next();
    idle(); settle();
`ifndef BRAM_IF_RAW_BYPASS_EN
    chk("stall_ready", 32'(HREADYOUT), 32'h0);
    chk("stall_rdaddr", 32'(BRAM_RDADDR), 32'h8);
`endif
    waits = 0;
    while (HREADYOUT !== 1'b1 && waits < 4) begin
      next(); settle(); waits++;
    end
`ifdef BRAM_IF_RAW_BYPASS_EN
    chk("raw_waits", 32'(waits), 32'h0);
`else
    chk("raw_waits", 32'(waits), 32'h1);
`endif
    chk("raw_data", HRDATA, 32'h55660000);
    next();

    // Write 0x30 then read different word 0x34: no wait, old data.
    drive(1'b1, 2'b10, 1'b1, 32'h30, 3'd2); settle(); next();
    HWDATA = 32'h30303030; drive(1'b1, 2'b10, 1'b0, 32'h34, 3'd2); settle();
    chk("r34_rdaddr", 32'(BRAM_RDADDR), 32'hD);
    chk("w30_addr", 32'(BRAM_WRADDR), 32'hC);
    chk("w30_mask", 32'(BRAM_WRITE), 32'hF);
    next();
    idle(); settle();
    chk("r34_ready", 32'(HREADYOUT), 32'h1);
    chk("r34_data", HRDATA, 32'hC0DE0034);
    next();

    // Deselected and BUSY transfers must not write.
    drive(1'b0, 2'b10, 1'b1, 32'h40, 3'd2); settle(); next();
    HWDATA = 32'hFFFFFFFF; drive(1'b1, 2'b01, 1'b1, 32'h40, 3'd2); settle();
    chk("desel_nowrite", 32'(BRAM_WRITE), 32'h0);
    next();
    idle(); settle();
    chk("busy_nowrite", 32'(BRAM_WRITE), 32'h0);
    next();

    // Reset pulse during write data phase to 0x40.
    drive(1'b1, 2'b10, 1'b1, 32'h40, 3'd2); settle(); next();
    idle(); HWDATA = 32'hBADBAD00; #1;
    chk("w40_mask", 32'(BRAM_WRITE), 32'hF);
    HRESETn = 1'b0; #1;
    chk("w40_rst_nowrite", 32'(BRAM_WRITE), 32'h0);
    settle(); next();
    HRESETn = 1'b1; settle();
    chk("w40_after_rst", 32'(BRAM_WRITE), 32'h0);
    next();
    drive(1'b1, 2'b10, 1'b0, 32'h40, 3'd2); settle(); next();
    idle(); settle();
    chk("r40_data", HRDATA, 32'h40404040);
    next();

    // Reset during a hazard stall abandons the stall.
    drive(1'b1, 2'b10, 1'b1, 32'h50, 3'd2); settle(); next();
    HWDATA = 32'h12345678; drive(1'b1, 2'b10, 1'b0, 32'h50, 3'd2); settle(); next();
    idle(); settle();
`ifndef BRAM_IF_RAW_BYPASS_EN
    chk("stall2_ready", 32'(HREADYOUT), 32'h0);
`endif
    HRESETn = 1'b0; #1;
    chk("stall2_rst_ready", 32'(HREADYOUT), 32'h1);
    next();
    HRESETn = 1'b1; settle();
    chk("stall2_after_ready", 32'(HREADYOUT), 32'h1);
    chk("stall2_after_write", 32'(BRAM_WRITE), 32'h0);
    next();

    // Low-lane byte and halfword masks.
    drive(1'b1, 2'b10, 1'b1, 32'h44, 3'd0); settle(); next();
    HWDATA = 32'h000000EE; drive(1'b1, 2'b10, 1'b1, 32'h48, 3'd1); settle();
    chk("w44_mask", 32'(BRAM_WRITE), 32'h1);
    next();
    HWDATA = 32'h00007777; drive(1'b1, 2'b10, 1'b1, 32'h45, 3'd0); settle();
    chk("w48_mask", 32'(BRAM_WRITE), 32'h3);
    chk("w48_addr", 32'(BRAM_WRADDR), 32'h12);
    next();
    HWDATA = 32'h0000BB00; idle(); settle();
    chk("w45_mask", 32'(BRAM_WRITE), 32'h2);
    next();
    drive(1'b1, 2'b10, 1'b0, 32'h44, 3'd2); settle(); next();
    idle(); settle();
    chk("r44_data", HRDATA, 32'h0000BBEE);
    next();

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
